// File: rtl/battery_bank_manager.sv
// battery_bank_manager
// N-channel battery bank controller. Each battery's level is classified as
// empty / low / full, each classification is debounced independently, and a
// three-state selection FSM connects the load to one non-empty battery at a
// time. When the active battery empties, the FSM breaks the load for one
// cycle before making the connection to the next available battery.
// Every output is driven straight from a register.

module battery_bank_manager #(
  parameter int WIDTH    = 4,
  parameter int N_BATT   = 2,
  parameter int EMPTY_TH = 0,
  parameter int LOW_TH   = 3,
  parameter int DEBOUNCE = 3,
  parameter int SEL_W    = ($clog2(N_BATT) > 1) ? $clog2(N_BATT) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_BATT*WIDTH-1:0]   batt_level,
  output logic [N_BATT-1:0]         is_empty,
  output logic [N_BATT-1:0]         is_low,
  output logic                      all_full,
  output logic [SEL_W-1:0]          active_sel,
  output logic                      load_en,
  output logic                      switch_event,
  output logic [1:0]                led_state
);

  localparam int CNT_W = $clog2(DEBOUNCE) + 1;

  localparam logic [WIDTH-1:0] EMPTY_LVL = WIDTH'(EMPTY_TH);
  localparam logic [WIDTH-1:0] LOW_LVL   = WIDTH'(LOW_TH);
  localparam logic [WIDTH-1:0] FULL_LVL  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE - 1);

  localparam logic [1:0] LED_ALL_EMPTY = 2'b00;
  localparam logic [1:0] LED_LOW       = 2'b01;
  localparam logic [1:0] LED_NORMAL    = 2'b10;
  localparam logic [1:0] LED_ALL_FULL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    RUN    = 2'd2
  } stateT;

  // Raw (undebounced) classifications
  logic [N_BATT-1:0] emptyRaw;
  logic [N_BATT-1:0] lowRaw;
  logic [N_BATT-1:0] fullRaw;

  // Debounced flags and their per-flag counters
  logic [N_BATT-1:0] isEmptyR;
  logic [N_BATT-1:0] isLowR;
  logic [N_BATT-1:0] fullR;
  logic              allFullR;
  logic [CNT_W-1:0]  emptyCnt [N_BATT];
  logic [CNT_W-1:0]  lowCnt   [N_BATT];
  logic [CNT_W-1:0]  fullCnt  [N_BATT];

  // Selection FSM state and registered outputs
  stateT             state;
  stateT             nextState;
  logic [SEL_W-1:0]  activeSel;
  logic              loadEn;
  logic              switchEvent;
  logic [1:0]        ledState;

  // Search results and next values of the registered outputs
  logic              lowFound;
  logic [SEL_W-1:0]  lowIdx;
  logic              wrapFound;
  logic [SEL_W-1:0]  wrapIdx;
  logic [SEL_W-1:0]  target;
  logic [SEL_W-1:0]  nextActiveSel;
  logic              nextLoadEn;
  logic              nextSwitchEvent;
  logic [1:0]        nextLedState;

  // One debounce step: returns {newFlag, newCount}. The counter only runs
  // while raw disagrees with the flag; the flag flips on the DEBOUNCE-th
  // consecutive disagreeing sample.
  function automatic logic [CNT_W:0] debStep(
    input logic             raw,
    input logic             flag,
    input logic [CNT_W-1:0] cnt
  );
    logic [CNT_W:0] res;
    if (raw == flag) begin
      res = {flag, {CNT_W{1'b0}}};
    end else if (cnt == CNT_LAST) begin
      res = {~flag, {CNT_W{1'b0}}};
    end else begin
      res = {flag, cnt + CNT_W'(1)};
    end
    return res;
  endfunction

  // Classify every battery level against the thresholds
  always_comb begin
    // NOTE: every combinational output gets a default before any branch or loop, so no path can leave it unassigned and infer a latch.
    emptyRaw = '0;
    lowRaw   = '0;
    fullRaw  = '0;
    for (int i = 0; i < N_BATT; i++) begin
      emptyRaw[i] = (batt_level[i*WIDTH +: WIDTH] <= EMPTY_LVL);
      lowRaw[i]   = (batt_level[i*WIDTH +: WIDTH] <= LOW_LVL);
      fullRaw[i]  = (batt_level[i*WIDTH +: WIDTH] == FULL_LVL);
    end
  end

  // Debounce the three flags of every battery and register the bank-full AND
  always_ff @(posedge clk) begin
    if (rst) begin
      isEmptyR <= '1;
      isLowR   <= '1;
      fullR    <= '0;
      allFullR <= 1'b0;
      // NOTE: the counter arrays are ordinary flops, not RAM, so they are cleared here with the rest of the state.
      for (int i = 0; i < N_BATT; i++) begin
        emptyCnt[i] <= '0;
        lowCnt[i]   <= '0;
        fullCnt[i]  <= '0;
      end
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples the pre-edge values of the others.
      for (int i = 0; i < N_BATT; i++) begin
        {isEmptyR[i], emptyCnt[i]} <= debStep(emptyRaw[i], isEmptyR[i], emptyCnt[i]);
        {isLowR[i],   lowCnt[i]}   <= debStep(lowRaw[i],   isLowR[i],   lowCnt[i]);
        {fullR[i],    fullCnt[i]}  <= debStep(fullRaw[i],  fullR[i],    fullCnt[i]);
      end
      allFullR <= &fullR;
    end
  end

  // Lowest-index non-empty battery, used when leaving IDLE
  always_comb begin
    lowFound = 1'b0;
    lowIdx   = '0;
    for (int i = 0; i < N_BATT; i++) begin
      if (!lowFound && !isEmptyR[i]) begin
        lowFound = 1'b1;
        lowIdx   = SEL_W'(i);
      end
    end
  end

  // First non-empty battery above the active one, wrapping, active excluded
  always_comb begin
    int idx;
    wrapFound = 1'b0;
    wrapIdx   = activeSel;
    idx       = 0;
    for (int k = 1; k < N_BATT; k++) begin
      idx = int'(activeSel) + k;
      if (idx >= N_BATT) begin
        idx = idx - N_BATT;
      end
      if (!wrapFound && !isEmptyR[idx]) begin
        wrapFound = 1'b1;
        wrapIdx   = SEL_W'(idx);
      end
    end
  end

  // Selection FSM: state register plus the registered outputs it produces
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      activeSel   <= '0;
      loadEn      <= 1'b0;
      switchEvent <= 1'b0;
      ledState    <= LED_ALL_EMPTY;
    end else begin
      state       <= nextState;
      activeSel   <= nextActiveSel;
      loadEn      <= nextLoadEn;
      switchEvent <= nextSwitchEvent;
      ledState    <= nextLedState;
    end
  end

  // Selection FSM: next state and the battery to connect on SWITCH entry
  always_comb begin
    nextState = state;
    target    = activeSel;
    unique case (state)
      IDLE: begin
        if (lowFound) begin
          nextState = SWITCH;
          target    = lowIdx;
        end
      end
      SWITCH: begin
        nextState = RUN;
      end
      RUN: begin
        if (isEmptyR[activeSel]) begin
          if (wrapFound) begin
            nextState = SWITCH;
            target    = wrapIdx;
          end else begin
            nextState = IDLE;
          end
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Selection FSM outputs, computed one cycle ahead and registered above
  always_comb begin
    nextLoadEn      = (nextState == RUN);
    nextSwitchEvent = (state == RUN) && (nextState == SWITCH);
    nextActiveSel   = (nextState == SWITCH) ? target : activeSel;
    if (&isEmptyR) begin
      nextLedState = LED_ALL_EMPTY;
    end else if (allFullR) begin
      nextLedState = LED_ALL_FULL;
    end else if (isLowR[activeSel]) begin
      nextLedState = LED_LOW;
    end else begin
      nextLedState = LED_NORMAL;
    end
  end

  assign is_empty     = isEmptyR;
  assign is_low       = isLowR;
  assign all_full     = allFullR;
  assign active_sel   = activeSel;
  assign load_en      = loadEn;
  assign switch_event = switchEvent;
  assign led_state    = ledState;

endmodule

// File: tb/tb_battery_bank_manager.sv
// tb_battery_bank_manager
// Directed bench: a two-battery instance walks the bring-up, glitch,
// switch-over, all-empty and all-full scenarios; a four-battery instance
// covers the wrapping search and reset asserted during SWITCH.
// Inputs change on the falling edge, outputs are sampled on the falling edge.

module tb_battery_bank_manager;

  logic        clk;
  logic        rstA;
  logic [7:0]  lvlA;
  logic [1:0]  isEmptyA;
  logic [1:0]  isLowA;
  logic        allFullA;
  logic [0:0]  selA;
  logic        loadEnA;
  logic        swEvA;
  logic [1:0]  ledA;

  logic        rstB;
  logic [15:0] lvlB;
  logic [3:0]  isEmptyB;
  logic [3:0]  isLowB;
  logic        allFullB;
  logic [1:0]  selB;
  logic        loadEnB;
  logic        swEvB;
  logic [1:0]  ledB;

  int nAsserts = 0;
  int nFail    = 0;

  battery_bank_manager #(
    .WIDTH(4), .N_BATT(2), .EMPTY_TH(0), .LOW_TH(3), .DEBOUNCE(3)
  ) dutA (
    .clk(clk), .rst(rstA), .batt_level(lvlA),
    .is_empty(isEmptyA), .is_low(isLowA), .all_full(allFullA),
    .active_sel(selA), .load_en(loadEnA), .switch_event(swEvA),
    .led_state(ledA)
  );

  battery_bank_manager #(
    .WIDTH(4), .N_BATT(4), .EMPTY_TH(0), .LOW_TH(3), .DEBOUNCE(3)
  ) dutB (
    .clk(clk), .rst(rstB), .batt_level(lvlB),
    .is_empty(isEmptyB), .is_low(isLowB), .all_full(allFullB),
    .active_sel(selB), .load_en(loadEnB), .switch_event(swEvB),
    .led_state(ledB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rstA = 1'b1;
    rstB = 1'b1;
    lvlA = 8'h00;
    lvlB = 16'h0000;
    tick(2);

    // Reset state, two-battery instance
    check("rstEmpty",  32'(isEmptyA), 32'h3);
    check("rstLow",    32'(isLowA),   32'h3);
    check("rstFull",   32'(allFullA), 32'h0);
    check("rstSel",    32'(selA),     32'h0);
    check("rstLoad",   32'(loadEnA),  32'h0);
    check("rstSwEv",   32'(swEvA),    32'h0);
    check("rstLed",    32'(ledA),     32'h0);

    // Bring-up: both at 7
    rstA = 1'b0;
    lvlA = {4'd7, 4'd7};
    tick(2);
    check("upEmpty2",  32'(isEmptyA), 32'h3);
    tick(1);
    check("upEmpty3",  32'(isEmptyA), 32'h0);
    check("upLow3",    32'(isLowA),   32'h0);
    check("upLoad3",   32'(loadEnA),  32'h0);
    tick(1);
    check("upLoad4",   32'(loadEnA),  32'h0);
    check("upSwEv4",   32'(swEvA),    32'h0);
    tick(1);
    check("upLoad5",   32'(loadEnA),  32'h1);
    check("upSel5",    32'(selA),     32'h0);
    check("upLed5",    32'(ledA),     32'h2);

    // Two-cycle glitch on battery 0 must not change anything
    lvlA = {4'd7, 4'd0};
    tick(2);
    check("glEmpty2",  32'(isEmptyA), 32'h0);
    lvlA = {4'd7, 4'd7};
    tick(2);
    check("glEmpty",   32'(isEmptyA), 32'h0);
    check("glSwEv",    32'(swEvA),    32'h0);
    check("glSel",     32'(selA),     32'h0);
    check("glLoad",    32'(loadEnA),  32'h1);

    // Battery 0 empties, battery 1 low: break-before-make to battery 1
    lvlA = {4'd3, 4'd0};
    tick(3);
    check("swEmpty",   32'(isEmptyA), 32'h1);
    check("swLoadT",   32'(loadEnA),  32'h1);
    tick(1);
    check("swEv",      32'(swEvA),    32'h1);
    check("swLoadOff", 32'(loadEnA),  32'h0);
    check("swSel",     32'(selA),     32'h1);
    tick(1);
    check("swLoadOn",  32'(loadEnA),  32'h1);
    check("swEvEnd",   32'(swEvA),    32'h0);
    check("swLow",     32'(isLowA),   32'h3);
    check("swLed",     32'(ledA),     32'h1);

    // Both empty: back to IDLE, selection held
    lvlA = {4'd0, 4'd0};
    tick(3);
    check("aeEmpty",   32'(isEmptyA), 32'h3);
    check("aeLoadT",   32'(loadEnA),  32'h1);
    tick(1);
    check("aeLoad",    32'(loadEnA),  32'h0);
    check("aeSwEv",    32'(swEvA),    32'h0);
    check("aeSel",     32'(selA),     32'h1);
    check("aeLed",     32'(ledA),     32'h0);

    // Battery 0 recovers to 12: IDLE -> SWITCH -> RUN on battery 0
    lvlA = {4'd0, 4'd12};
    tick(3);
    check("reEmpty",   32'(isEmptyA), 32'h2);
    tick(1);
    check("reSel",     32'(selA),     32'h0);
    check("reLoadOff", 32'(loadEnA),  32'h0);
    check("reSwEv",    32'(swEvA),    32'h0);
    tick(1);
    check("reLoadOn",  32'(loadEnA),  32'h1);

    // Both full: all_full one cycle after the full flags, then LED 11
    lvlA = {4'd15, 4'd15};
    tick(3);
    check("fuFull3",   32'(allFullA), 32'h0);
    check("fuEmpty3",  32'(isEmptyA), 32'h0);
    tick(1);
    check("fuFull4",   32'(allFullA), 32'h1);
    tick(1);
    check("fuLed",     32'(ledA),     32'h3);
    check("fuLoad",    32'(loadEnA),  32'h1);
    check("fuSel",     32'(selA),     32'h0);

    // Four-battery instance: only battery 3 available
    rstB = 1'b0;
    lvlB = {4'd9, 4'd0, 4'd0, 4'd0};
    tick(3);
    check("b4Empty",   32'(isEmptyB), 32'h7);
    tick(1);
    check("b4Sel",     32'(selB),     32'h3);
    check("b4SwEv",    32'(swEvB),    32'h0);
    tick(1);
    check("b4Load",    32'(loadEnB),  32'h1);

    // Battery 3 empties, 0 empty, 1 at 9: wrap skips 0 and selects 1
    lvlB = {4'd0, 4'd0, 4'd9, 4'd0};
    tick(3);
    check("wrEmpty",   32'(isEmptyB), 32'hD);
    tick(1);
    check("wrSel",     32'(selB),     32'h1);
    check("wrSwEv",    32'(swEvB),    32'h1);
    check("wrLoadOff", 32'(loadEnB),  32'h0);
    tick(1);
    check("wrLoadOn",  32'(loadEnB),  32'h1);

    // Reset asserted while in SWITCH
    lvlB = {4'd0, 4'd9, 4'd0, 4'd0};
    tick(3);
    check("rsEmpty",   32'(isEmptyB), 32'hB);
    tick(1);
    check("rsSwEv",    32'(swEvB),    32'h1);
    check("rsSel2",    32'(selB),     32'h2);
    rstB = 1'b1;
    tick(1);
    check("rsLoad",    32'(loadEnB),  32'h0);
    check("rsSel",     32'(selB),     32'h0);
    check("rsEmptyR",  32'(isEmptyB), 32'hF);
    check("rsLed",     32'(ledB),     32'h0);
    check("rsSwEvR",   32'(swEvB),    32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
